// File: rtl/serial_word_deframer_if.sv
// Word-stream port of the serial deframer: one assembled word per transfer,
// tagged with frame boundary flags, moved by a valid/ready handshake.
interface serial_word_deframer_if #(
  parameter int WIDTH = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             frame_start;
  logic             frame_end;

  // Producer side: the deframer drives the word and its flags.
  modport master (
    output out_valid,
    output out_data,
    output frame_start,
    output frame_end,
    input  out_ready
  );

  // Consumer side: the word-level datapath accepts words.
  modport slave (
    input  out_valid,
    input  out_data,
    input  frame_start,
    input  frame_end,
    output out_ready
  );
endinterface

// File: rtl/serial_word_deframer.sv
// Serial word deframer.
// Watches a qualified serial bit stream for a sync pattern, then slices the
// following FRAME_WORDS * WIDTH bits into words and hands each one to the
// consumer through a one-deep output register with valid/ready handshake.
// A word that completes while the previous one is still waiting is dropped
// and latched in the sticky overrun flag.
module serial_word_deframer #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD   = WIDTH'(8'hA5),
  parameter int               FRAME_WORDS = 4,
  parameter bit               MSB_FIRST   = 1'b1
) (
  input  logic                   clock,
  input  logic                   sclr,
  input  logic                   bit_valid,
  input  logic                   serial_in,
  serial_word_deframer_if.master words,
  output logic                   locked,
  output logic                   overrun
);

  // Counter widths. fill_cnt must be able to hold WIDTH itself (saturation).
  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int WORD_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(WIDTH);
  localparam logic [FILL_W-1:0] FILL_LOCK = FILL_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(FRAME_WORDS - 1);

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t            state_reg;
  logic [WIDTH-1:0]  window_reg;
  logic [WIDTH-1:0]  win_next;
  logic [FILL_W-1:0] fill_cnt_reg;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [WORD_W-1:0] word_cnt_reg;
  logic              locked_reg;

  logic              out_valid_reg;
  logic [WIDTH-1:0]  out_data_reg;
  logic              frame_start_reg;
  logic              frame_end_reg;
  logic              overrun_reg;

  logic              sync_hit;
  logic              word_done;
  logic              last_word;

  // Window shift: each accepted bit enters at the end the first bit leaves
  // from, so after WIDTH bits the first received bit sits at the MSB
  // (MSB_FIRST) or at the LSB (LSB first).
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_win
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_in
          assign win_next[gi] = serial_in;
        end else begin : g_sh
          assign win_next[gi] = window_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_in
          assign win_next[gi] = serial_in;
        end else begin : g_sh
          assign win_next[gi] = window_reg[gi+1];
        end
      end
    end
  endgenerate

  // A match only counts once WIDTH real bits have been accepted, so reset
  // zeros (or leftovers of the previous frame) can never fake a lock.
  assign sync_hit  = bit_valid && (state_reg == HUNT) &&
                     (win_next == SYNC_WORD) && (fill_cnt_reg >= FILL_LOCK);
  assign word_done = bit_valid && (state_reg == COLLECT) && (bit_cnt_reg == BIT_LAST);
  assign last_word = (word_cnt_reg == WORD_LAST);

  // Framing FSM: hunt for sync, then count bits and words of the payload.
  always_ff @(posedge clock) begin
    if (sclr) begin
      state_reg    <= HUNT;
      window_reg   <= '0;
      fill_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      word_cnt_reg <= '0;
      locked_reg   <= 1'b0;
    end else if (bit_valid) begin
      window_reg <= win_next;
      case (state_reg)
        HUNT: begin
          if (fill_cnt_reg != FILL_MAX) begin
            fill_cnt_reg <= fill_cnt_reg + 1'b1;
          end
          if (sync_hit) begin
            state_reg    <= COLLECT;
            bit_cnt_reg  <= '0;
            word_cnt_reg <= '0;
            locked_reg   <= 1'b1;
          end
        end
        COLLECT: begin
          if (word_done) begin
            bit_cnt_reg <= '0;
            if (last_word) begin
              // Frame finished: demand a complete fresh sync word next.
              state_reg    <= HUNT;
              fill_cnt_reg <= '0;
              word_cnt_reg <= '0;
              locked_reg   <= 1'b0;
            end else begin
              word_cnt_reg <= word_cnt_reg + 1'b1;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg  <= HUNT;
          locked_reg <= 1'b0;
        end
      endcase
    end
  end

  // Output register: load a completed word when the slot is free or being
  // emptied this cycle; otherwise keep the held word and flag the drop.
  always_ff @(posedge clock) begin
    if (sclr) begin
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      frame_start_reg <= 1'b0;
      frame_end_reg   <= 1'b0;
      overrun_reg     <= 1'b0;
    end else if (word_done) begin
      if (!out_valid_reg || words.out_ready) begin
        out_valid_reg   <= 1'b1;
        out_data_reg    <= win_next;
        frame_start_reg <= (word_cnt_reg == '0);
        frame_end_reg   <= last_word;
      end else begin
        overrun_reg <= 1'b1;
      end
    end else if (out_valid_reg && words.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign words.out_valid   = out_valid_reg;
  assign words.out_data    = out_data_reg;
  assign words.frame_start = frame_start_reg;
  assign words.frame_end   = frame_end_reg;
  assign locked            = locked_reg;
  assign overrun           = overrun_reg;

endmodule

// File: tb/tb_serial_word_deframer.sv
// Bench for serial_word_deframer: two instances share one serial stream
// (A5 sync / 4 words / MSB first, and 00 sync / 1 word / LSB first) and are
// compared every cycle against a bit-list reference model.
module tb_serial_word_deframer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic sclr      = 1'b1;
  logic bit_valid = 1'b0;
  logic serial_in = 1'b0;
  logic out_ready = 1'b1;
  logic locked0, overrun0, locked1, overrun1;
  bit   chk_en    = 1'b0;

  serial_word_deframer_if #(.WIDTH(8)) w0 ();
  serial_word_deframer_if #(.WIDTH(8)) w1 ();
  assign w0.out_ready = out_ready;
  assign w1.out_ready = out_ready;

  serial_word_deframer #(
    .WIDTH(8), .SYNC_WORD(8'hA5), .FRAME_WORDS(4), .MSB_FIRST(1'b1)
  ) u_dut0 (
    .clock(clock), .sclr(sclr), .bit_valid(bit_valid), .serial_in(serial_in),
    .words(w0.master), .locked(locked0), .overrun(overrun0)
  );

  serial_word_deframer #(
    .WIDTH(8), .SYNC_WORD(8'h00), .FRAME_WORDS(1), .MSB_FIRST(1'b0)
  ) u_dut1 (
    .clock(clock), .sclr(sclr), .bit_valid(bit_valid), .serial_in(serial_in),
    .words(w1.master), .locked(locked1), .overrun(overrun1)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: list of recent bits while hunting, list of payload bits
  // while locked, plus the one-slot output buffer.
  bit [7:0] p_sync [2] = '{8'hA5, 8'h00};
  int       p_fw   [2] = '{4, 1};
  bit       p_msb  [2] = '{1'b1, 1'b0};

  bit       m_lk   [2];
  int       m_hn   [2];
  bit       m_hist [2][8];
  int       m_pn   [2];
  bit       m_pay  [2][8];
  int       m_wc   [2];
  bit       m_ev   [2];
  bit [7:0] m_ed   [2];
  bit       m_fs   [2];
  bit       m_fe   [2];
  bit       m_ov   [2];

  task automatic model_step(input int i);
    bit nw;
    int v;
    bit nfs, nfe;
    nw = 0; v = 0; nfs = 0; nfe = 0;
    if (sclr) begin
      m_lk[i] = 0; m_hn[i] = 0; m_pn[i] = 0; m_wc[i] = 0;
      m_ev[i] = 0; m_ed[i] = 8'h00; m_fs[i] = 0; m_fe[i] = 0; m_ov[i] = 0;
    end else begin
      if (bit_valid) begin
        if (!m_lk[i]) begin
          if (m_hn[i] == 8) begin
            for (int j = 0; j < 7; j++) m_hist[i][j] = m_hist[i][j+1];
            m_hist[i][7] = serial_in;
          end else begin
            m_hist[i][m_hn[i]] = serial_in;
            m_hn[i]++;
          end
          if (m_hn[i] == 8) begin
            for (int j = 0; j < 8; j++)
              if (m_hist[i][j]) v += p_msb[i] ? (1 << (7 - j)) : (1 << j);
            if (v == int'(p_sync[i])) begin
              m_lk[i] = 1; m_pn[i] = 0; m_wc[i] = 0;
            end
          end
        end else begin
          m_pay[i][m_pn[i]] = serial_in;
          m_pn[i]++;
          if (m_pn[i] == 8) begin
            for (int j = 0; j < 8; j++)
              if (m_pay[i][j]) v += p_msb[i] ? (1 << (7 - j)) : (1 << j);
            nw  = 1;
            nfs = (m_wc[i] == 0);
            nfe = (m_wc[i] == p_fw[i] - 1);
            m_wc[i]++;
            m_pn[i] = 0;
            if (m_wc[i] == p_fw[i]) begin
              m_lk[i] = 0; m_hn[i] = 0;
            end
          end
        end
      end
      if (m_ev[i] && out_ready)
        $display("xfer dut%0d data=%h start=%0d end=%0d t=%0t", i, m_ed[i], m_fs[i], m_fe[i], $time);
      if (nw) begin
        if (!m_ev[i] || out_ready) begin
          m_ev[i] = 1; m_ed[i] = 8'(v); m_fs[i] = nfs; m_fe[i] = nfe;
        end else begin
          m_ov[i] = 1;
        end
      end else if (m_ev[i] && out_ready) begin
        m_ev[i] = 0;
      end
    end
  endtask

  always @(posedge clock) begin
    model_step(0);
    model_step(1);
  end

  // Words actually delivered by dut0, for frame-level checks.
  logic [7:0] got_q[$];
  always @(posedge clock)
    if (!sclr && w0.out_valid && out_ready) got_q.push_back(w0.out_data);

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check_val("d0 out_valid",   w0.out_valid,   m_ev[0]);
      check_val("d0 out_data",    w0.out_data,    m_ed[0]);
      check_val("d0 frame_start", w0.frame_start, m_fs[0]);
      check_val("d0 frame_end",   w0.frame_end,   m_fe[0]);
      check_val("d0 locked",      locked0,        m_lk[0]);
      check_val("d0 overrun",     overrun0,       m_ov[0]);
      check_val("d1 out_valid",   w1.out_valid,   m_ev[1]);
      check_val("d1 out_data",    w1.out_data,    m_ed[1]);
      check_val("d1 frame_start", w1.frame_start, m_fs[1]);
      check_val("d1 frame_end",   w1.frame_end,   m_fe[1]);
      check_val("d1 locked",      locked1,        m_lk[1]);
      check_val("d1 overrun",     overrun1,       m_ov[1]);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    sclr = 1'b1;
    bit_valid = 1'b0;
    repeat (n) tick();
    sclr = 1'b0;
    got_q.delete();
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    serial_in = b;
    tick();
    bit_valid = 1'b0;
  endtask

  // Byte sent MSB first on the wire; gap_pct adds random idle (bit_valid=0) cycles.
  task automatic send_byte(input logic [7:0] val, input int gap_pct);
    for (int j = 7; j >= 0; j--) begin
      for (int k = 0; k < 6 && $urandom_range(99) < gap_pct; k++) begin
        bit_valid = 1'b0;
        serial_in = 1'($urandom_range(1));
        tick();
      end
      send_bit(val[j]);
    end
  endtask

  task automatic send_frame(input logic [7:0] a, b, c, d, input int gap_pct);
    send_byte(8'hA5, gap_pct);
    send_byte(a, gap_pct);
    send_byte(b, gap_pct);
    send_byte(c, gap_pct);
    send_byte(d, gap_pct);
  endtask

  task automatic expect_frame(input logic [7:0] a, b, c, d);
    logic [7:0] exp [4];
    exp[0] = a; exp[1] = b; exp[2] = c; exp[3] = d;
    check_val("d0 word count", got_q.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < got_q.size()) check_val("d0 frame word", got_q[k], exp[k]);
    got_q.delete();
  endtask

  initial begin
    // 1: reset held two cycles from power-up X.
    tick();
    chk_en = 1'b1;
    do_reset(2);
    check_val("reset locked", locked0, 1'b0);
    check_val("reset valid",  w0.out_valid, 1'b0);

    // 2: plain frame, consumer always ready.
    out_ready = 1'b1;
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 0);
    idle(3);
    expect_frame(8'h11, 8'h22, 8'h33, 8'h44);

    // 3: misaligned prefix, then the zero-sync instance needs 8 real zeros.
    do_reset(1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 0);
    idle(3);
    expect_frame(8'h11, 8'h22, 8'h33, 8'h44);
    do_reset(1);
    repeat (7) send_bit(1'b0);
    check_val("d1 no lock on 7 zeros", locked1, 1'b0);
    send_bit(1'b0);
    check_val("d1 lock on 8th zero", locked1, 1'b1);
    send_byte(8'h1E, 0);
    idle(2);

    // 4: consumer stalled for the whole frame.
    do_reset(1);
    out_ready = 1'b0;
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 0);
    idle(2);
    check_val("stall held data", w0.out_data, 8'h11);
    check_val("stall overrun",   overrun0,    1'b1);
    out_ready = 1'b1;
    idle(3);
    check_val("stall delivered count", got_q.size(), 1);
    if (got_q.size() > 0) check_val("stall delivered word", got_q[0], 8'h11);
    check_val("overrun sticky", overrun0, 1'b1);

    // 5: random bit_valid gaps, then random frames with random backpressure.
    do_reset(1);
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 50);
    idle(3);
    expect_frame(8'h11, 8'h22, 8'h33, 8'h44);
    for (int f = 0; f < 6; f++) begin
      send_byte(8'hA5, 30);
      for (int k = 0; k < 4; k++) begin
        out_ready = ($urandom_range(3) != 0);
        send_byte(8'($urandom_range(255)), 30);
      end
      out_ready = 1'b1;
      idle(2);
    end

    // 6: reset arrives after the second payload word.
    do_reset(1);
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 0);
    do_reset(1);
    send_byte(8'hA5, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_reset(1);
    check_val("midframe reset locked", locked0, 1'b0);
    check_val("midframe reset valid",  w0.out_valid, 1'b0);
    send_frame(8'h55, 8'h66, 8'h77, 8'h88, 0);
    idle(3);
    expect_frame(8'h55, 8'h66, 8'h77, 8'h88);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
